median_filter_scheduler: RTL and testbench
==========================================

Name: median_filter_scheduler

Overview:
- Round-robin scheduler that shares one MedianFilter instance (8 samples x 4 bit, packed into 32 bits) between NUM_REQ requesters.
- Accepts one packed sample word at a time from a valid/ready request port and drives it into the filter.
- Waits the filter's fixed pipeline latency, then captures the sorted word and median and returns them to the granted requester on a valid/ready response port.
- Sits between on-chip clients (APB register front-end, DMA stub) and the filter datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUS_WIDTH, 32, packed sample word width (8 samples x 4 bit).
- FILT_LAT, 2, filter clocks from filt_in change to stable filt_sorted/filt_mid (>=1).

Ports:
- S_CLK  in  1  clock.
- S_RST  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*BUS_WIDTH  packed sample words; requester i uses bits [i*BUS_WIDTH +: BUS_WIDTH].
- req_ready  out  NUM_REQ  one-hot accept.
- rsp_valid  out  NUM_REQ  one-hot response valid.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_sorted  out  BUS_WIDTH  captured filter sorted output, shared by all requesters.
- rsp_median  out  4  captured median, shared by all requesters.
- filt_in  out  BUS_WIDTH  registered drive to MedianFilter input_data.
- filt_sorted  in  BUS_WIDTH  from MedianFilter output_data.
- filt_mid  in  4  from MedianFilter mid.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset (async, S_RST=1):
  - state=IDLE; filt_in=0; rsp_sorted=0; rsp_median=0; rsp_valid=0; req_ready=0; busy=0; grant_id=0; wait counter=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation abandons the transaction; no response is produced.
- FSM states: IDLE, WAIT, CAPTURE, RESP.
- IDLE:
  - Grant is combinational: first i with req_valid[i]=1, searching from pointer+1 upward with wrap modulo NUM_REQ.
  - req_ready[g]=1 only in IDLE and only for the granted g; all other bits 0.
  - On the clock edge where req_valid[g]&req_ready[g]=1: filt_in<=req_data slice g; grant_id<=g; counter<=FILT_LAT-1; next state WAIT.
  - No request valid: remain in IDLE; filt_in holds its last value.
- WAIT: counter decrements each cycle. At counter==0, next state CAPTURE. WAIT therefore lasts exactly FILT_LAT cycles.
- CAPTURE (1 cycle): rsp_sorted<=filt_sorted; rsp_median<=filt_mid; next state RESP.
- RESP:
  - rsp_valid[grant_id]=1, all other bits 0; rsp_sorted and rsp_median held stable.
  - Waits while rsp_ready[grant_id]=0. rsp_ready bits of non-granted requesters are ignored.
  - On rsp_valid&rsp_ready: pointer<=grant_id; next state IDLE. The next grant can occur one cycle later.
- Timing:
  - Accept-to-rsp_valid latency is FILT_LAT+2 cycles, with rsp_ready held high.
  - Minimum issue interval is FILT_LAT+3 cycles.
- Only one transaction is outstanding at a time. req_ready=0 everywhere outside IDLE.
- A requester may drop req_valid before being granted; there is no penalty and no state change.
- Simultaneous requests: exactly one grant per IDLE cycle. Round-robin order guarantees each waiting requester is served within NUM_REQ transactions.
- filt_in changes only on an accepted request. The filter input is stable for the whole WAIT and CAPTURE window.
- Width rules:
  - rsp_median is 4 bits, zero-extended by consumers.
  - grant_id width is max(1,$clog2(NUM_REQ)).

Test Plan:
- Reset, then req_valid[0]=1 with req_data0=0x55555555 and rsp_ready=1 → req_ready[0] pulses one cycle; filt_in=0x55555555 next cycle; rsp_valid[0]=1 exactly FILT_LAT+2 cycles after accept; rsp_sorted=0x55555555, rsp_median=5.
- req_valid=4'b1111 held continuously with distinct data → grant order 0,1,2,3,0. Each response carries the reference-model sort/median of its own word, and only the matching rsp_valid bit is asserted.
- Single response with rsp_ready low for 10 cycles → rsp_valid and rsp_sorted/rsp_median stable throughout; req_ready stays 0 even with req_valid=1111; grant occurs one cycle after rsp_ready rises.
- After requester 2 is served, req_valid=4'b0101 → requester 0 is granted before requester 2 is re-served, confirming round-robin wrap.
- Assert S_RST during WAIT → outputs at reset values immediately; rsp_valid never pulses; after release, requester 0 is granted first.
- req_valid[1] asserted then dropped while busy=1 → no grant to requester 1; filt_in unchanged until the next accepted request.

Source files
------------

// File: rtl/median_filter_scheduler_if.sv
// Request/response and filter-side signal bundle for median_filter_scheduler.
// The slave modport is the scheduler; the master modport is the clients plus the filter.
interface median_filter_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 32
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [NUM_REQ-1:0]           rsp_ready;
    logic [BUS_WIDTH-1:0]         rsp_sorted;
    logic [3:0]                   rsp_median;
    logic [BUS_WIDTH-1:0]         filt_in;
    logic [BUS_WIDTH-1:0]         filt_sorted;
    logic [3:0]                   filt_mid;
    logic                         busy;
    logic [GW-1:0]                grant_id;

    modport master (
        output req_valid, req_data, rsp_ready, filt_sorted, filt_mid,
        input  req_ready, rsp_valid, rsp_sorted, rsp_median, filt_in, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready, filt_sorted, filt_mid,
        output req_ready, rsp_valid, rsp_sorted, rsp_median, filt_in, busy, grant_id
    );
endinterface

// File: rtl/median_filter_scheduler.sv
// Round-robin scheduler sharing one median filter between NUM_REQ requesters,
// one transaction outstanding at a time.
//
// state   | meaning
// IDLE    | arbitrate; accept the granted request and drive filt_in
// WAIT    | down-count filter latency, terminal count at zero
// CAPTURE | register filt_sorted / filt_mid
// RESP    | hold rsp_valid to the granted requester until rsp_ready
module median_filter_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int BUS_WIDTH = 32,
    parameter int FILT_LAT  = 2
) (
    input  logic                         S_CLK,
    input  logic                         S_RST,
    median_filter_scheduler_if.slave     bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [CW-1:0]      CNT_LOAD = CW'(FILT_LAT - 1);
    localparam logic [GW-1:0]      PTR_RST  = GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [GW-1:0]        ptr;
    logic [GW-1:0]        grant_q;
    logic [BUS_WIDTH-1:0] filt_in_q;
    logic [BUS_WIDTH-1:0] rsp_sorted_q;
    logic [3:0]           rsp_median_q;

    logic                 gnt_found;
    logic [GW-1:0]        gnt_idx;
    logic [GW-1:0]        cand;
    logic                 accept;
    logic                 rsp_fire;

    // Scan downward so the candidate nearest to ptr+1 is the last one written.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GW'((int'(ptr) + k) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign accept   = (state == ST_IDLE) && gnt_found;
    assign rsp_fire = (state == ST_RESP) && bus.rsp_ready[grant_q];

    assign bus.req_ready  = (accept && !S_RST) ? (ONE_HOT0 << gnt_idx) : '0;
    assign bus.rsp_valid  = (state == ST_RESP) ? (ONE_HOT0 << grant_q) : '0;
    assign bus.rsp_sorted = rsp_sorted_q;
    assign bus.rsp_median = rsp_median_q;
    assign bus.filt_in    = filt_in_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.grant_id   = grant_q;

    always_ff @(posedge S_CLK or posedge S_RST) begin
        if (S_RST) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ptr          <= PTR_RST;
            grant_q      <= '0;
            filt_in_q    <= '0;
            rsp_sorted_q <= '0;
            rsp_median_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        filt_in_q <= bus.req_data[gnt_idx*BUS_WIDTH +: BUS_WIDTH];
                        grant_q   <= gnt_idx;
                        cnt       <= CNT_LOAD;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_CAPTURE: begin
                    rsp_sorted_q <= bus.filt_sorted;
                    rsp_median_q <= bus.filt_mid;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        ptr   <= grant_q;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_median_filter_scheduler.sv
// Self-checking bench: behavioural median-filter stub plus a queue-free
// round-robin reference for grant order, latency and returned data.
module tb_median_filter_scheduler;
    localparam int NR  = 4;
    localparam int BW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    median_filter_scheduler_if #(.NUM_REQ(NR), .BUS_WIDTH(BW)) bus ();

    median_filter_scheduler #(.NUM_REQ(NR), .BUS_WIDTH(BW), .FILT_LAT(LAT)) dut (
        .S_CLK (clk),
        .S_RST (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int m_ptr = NR - 1;
    logic [BW-1:0] words [NR];

    function automatic logic [BW-1:0] ref_sort(input logic [BW-1:0] w);
        int s [8];
        int t;
        logic [BW-1:0] r;
        for (int i = 0; i < 8; i++) s[i] = int'(w[i*4 +: 4]);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        r = '0;
        for (int i = 0; i < 8; i++) r[i*4 +: 4] = 4'(s[i]);
        return r;
    endfunction

    function automatic logic [3:0] ref_med(input logic [BW-1:0] w);
        logic [BW-1:0] s;
        s = ref_sort(w);
        return s[19:16];
    endfunction

    // Filter stub: LAT register stages from filt_in to the outputs.
    logic [BW-1:0] pipe_s [LAT];
    logic [3:0]    pipe_m [LAT];
    always @(posedge clk) begin
        pipe_s[0] <= ref_sort(bus.filt_in);
        pipe_m[0] <= ref_med(bus.filt_in);
        for (int i = 1; i < LAT; i++) begin
            pipe_s[i] <= pipe_s[i-1];
            pipe_m[i] <= pipe_m[i-1];
        end
    end
    assign bus.filt_sorted = pipe_s[LAT-1];
    assign bus.filt_mid    = pipe_m[LAT-1];

    function automatic int model_grant(input logic [NR-1:0] v, input int p);
        for (int k = 1; k <= NR; k++)
            if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic load_words();
        for (int i = 0; i < NR; i++) bus.req_data[i*BW +: BW] = words[i];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = NR - 1;
    endtask

    // Drives one transaction with rsp_ready high and records what the DUT did.
    task automatic run_txn(input logic [NR-1:0] vmask, output int g,
                           output logic [NR-1:0] rr_acc, output logic [NR-1:0] rr_next,
                           output logic [BW-1:0] filt_next, output logic [NR-1:0] rv,
                           output logic [BW-1:0] srt, output logic [3:0] med,
                           output int lat, output bit to);
        int c;
        g = -1; rr_acc = '0; rr_next = '0; filt_next = '0; rv = '0;
        srt = '0; med = '0; lat = 0; to = 1'b0; c = 0;
        @(negedge clk);
        bus.req_valid = vmask;
        bus.rsp_ready = '1;
        #1;
        while (bus.req_ready == '0 && c < 30) begin @(negedge clk); #1; c++; end
        if (bus.req_ready == '0) begin to = 1'b1; return; end
        rr_acc = bus.req_ready;
        g = oh_idx(bus.req_ready);
        @(negedge clk); #1;
        rr_next = bus.req_ready;
        filt_next = bus.filt_in;
        lat = 1;
        while (bus.rsp_valid == '0 && lat < 30) begin @(negedge clk); #1; lat++; end
        if (bus.rsp_valid == '0) begin to = 1'b1; return; end
        rv = bus.rsp_valid;
        srt = bus.rsp_sorted;
        med = bus.rsp_median;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
        total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.grant_id !== '0) begin bad++; $display("FAIL reset_grant_id got=%0d want=0", bus.grant_id); end
        total++; if (bus.filt_in !== '0) begin bad++; $display("FAIL reset_filt_in got=%h want=0", bus.filt_in); end
        total++; if (bus.rsp_sorted !== '0 || bus.rsp_median !== '0) begin bad++; $display("FAIL reset_rsp_data got=%h/%h want=0/0", bus.rsp_sorted, bus.rsp_median); end
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = NR - 1;
    endtask

    task automatic test_single();
        int g, lat; bit to;
        logic [NR-1:0] ra, rn, rv; logic [BW-1:0] fn, s; logic [3:0] m;
        words[0] = 32'h5555_5555;
        load_words();
        run_txn(4'b0001, g, ra, rn, fn, rv, s, m, lat, to);
        bus.req_valid = '0;
        total++; if (to) begin bad++; $display("FAIL single_timeout got=timeout want=response"); end
        total++; if (ra !== 4'b0001) begin bad++; $display("FAIL single_req_ready got=%b want=0001", ra); end
        total++; if (rn !== 4'b0000) begin bad++; $display("FAIL single_ready_pulse got=%b want=0000", rn); end
        total++; if (fn !== 32'h5555_5555) begin bad++; $display("FAIL single_filt_in got=%h want=55555555", fn); end
        total++; if (lat !== LAT + 2) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat, LAT + 2); end
        total++; if (rv !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid got=%b want=0001", rv); end
        total++; if (s !== 32'h5555_5555) begin bad++; $display("FAIL single_sorted got=%h want=55555555", s); end
        total++; if (m !== 4'd5) begin bad++; $display("FAIL single_median got=%0d want=5", m); end
        if (g >= 0) m_ptr = g;
    endtask

    task automatic test_round_robin();
        int g, lat, eg; bit to;
        logic [NR-1:0] ra, rn, rv; logic [BW-1:0] fn, s; logic [3:0] m;
        do_reset();
        for (int i = 0; i < NR; i++) words[i] = $urandom;
        load_words();
        for (int t = 0; t < 5; t++) begin
            eg = model_grant(4'b1111, m_ptr);
            run_txn(4'b1111, g, ra, rn, fn, rv, s, m, lat, to);
            total++; if (to) begin bad++; $display("FAIL rr_timeout txn=%0d got=timeout want=response", t); end
            total++; if (g !== eg) begin bad++; $display("FAIL rr_grant txn=%0d got=%0d want=%0d", t, g, eg); end
            total++; if (rv !== (NR'(1) << eg)) begin bad++; $display("FAIL rr_rsp_valid txn=%0d got=%b want=%b", t, rv, NR'(1) << eg); end
            total++; if (s !== ref_sort(words[eg]) || m !== ref_med(words[eg])) begin bad++; $display("FAIL rr_data txn=%0d got=%h/%h want=%h/%h", t, s, m, ref_sort(words[eg]), ref_med(words[eg])); end
            m_ptr = eg;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        int r, c, eg;
        logic [NR-1:0] vm;
        r = $urandom_range(0, NR - 1);
        vm = NR'(1) << r;
        words[r] = $urandom;
        load_words();
        c = 0;
        @(negedge clk);
        bus.req_valid = vm;
        bus.rsp_ready = ~vm;
        #1;
        while (bus.req_ready == '0 && c < 30) begin @(negedge clk); #1; c++; end
        total++; if (bus.req_ready !== vm) begin bad++; $display("FAIL bp_accept got=%b want=%b", bus.req_ready, vm); end
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1; c = 0;
        while (bus.rsp_valid == '0 && c < 30) begin @(negedge clk); #1; c++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            total++; if (bus.rsp_valid !== vm) begin bad++; $display("FAIL bp_rsp_valid cyc=%0d got=%b want=%b", i, bus.rsp_valid, vm); end
            total++; if (bus.rsp_sorted !== ref_sort(words[r]) || bus.rsp_median !== ref_med(words[r])) begin bad++; $display("FAIL bp_data cyc=%0d got=%h/%h want=%h/%h", i, bus.rsp_sorted, bus.rsp_median, ref_sort(words[r]), ref_med(words[r])); end
            total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b want=0", i, bus.req_ready); end
        end
        bus.rsp_ready = '1;
        m_ptr = r;
        eg = model_grant(4'b1111, m_ptr);
        @(negedge clk); #1;
        total++; if (bus.req_ready !== (NR'(1) << eg)) begin bad++; $display("FAIL bp_regrant got=%b want=%b", bus.req_ready, NR'(1) << eg); end
        bus.req_valid = '0;
    endtask

    task automatic test_wrap();
        int g, lat, eg; bit to;
        logic [NR-1:0] ra, rn, rv; logic [BW-1:0] fn, s; logic [3:0] m;
        do_reset();
        for (int i = 0; i < NR; i++) words[i] = $urandom;
        load_words();
        run_txn(4'b0100, g, ra, rn, fn, rv, s, m, lat, to);
        total++; if (g !== 2) begin bad++; $display("FAIL wrap_first got=%0d want=2", g); end
        m_ptr = 2;
        for (int t = 0; t < 2; t++) begin
            eg = model_grant(4'b0101, m_ptr);
            run_txn(4'b0101, g, ra, rn, fn, rv, s, m, lat, to);
            total++; if (g !== eg) begin bad++; $display("FAIL wrap_grant txn=%0d got=%0d want=%0d", t, g, eg); end
            total++; if (fn !== words[eg]) begin bad++; $display("FAIL wrap_filt_in txn=%0d got=%h want=%h", t, fn, words[eg]); end
            m_ptr = eg;
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_mid();
        int c;
        c = 0;
        @(negedge clk);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = '1;
        #1;
        while (bus.req_ready == '0 && c < 30) begin @(negedge clk); #1; c++; end
        @(negedge clk);
        bus.req_valid = 4'b1111;
        #1;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", bus.busy); end
        rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.grant_id !== '0) begin bad++; $display("FAIL rmid_state got=%b/%0d want=0/0", bus.busy, bus.grant_id); end
        total++; if (bus.filt_in !== '0) begin bad++; $display("FAIL rmid_filt_in got=%h want=0", bus.filt_in); end
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL rmid_req_ready got=%b want=0", bus.req_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL rmid_rsp_valid cyc=%0d got=%b want=0", i, bus.rsp_valid); end
        end
        rst = 1'b0;
        m_ptr = NR - 1;
        #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_first_grant got=%b want=0001", bus.req_ready); end
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            total++; if (bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_quiet cyc=%0d got=%b/%b want=0/0", i, bus.rsp_valid, bus.busy); end
        end
    endtask

    task automatic test_drop();
        int c, g, lat; bit to;
        logic [NR-1:0] ra, rn, rv; logic [BW-1:0] fn, s, held; logic [3:0] m;
        for (int i = 0; i < NR; i++) words[i] = $urandom;
        load_words();
        held = words[0];
        c = 0;
        @(negedge clk);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = '0;
        #1;
        while (bus.req_ready == '0 && c < 30) begin @(negedge clk); #1; c++; end
        @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        total++; if (bus.req_ready !== '0 || bus.busy !== 1'b1) begin bad++; $display("FAIL drop_while_busy got=%b/%b want=0000/1", bus.req_ready, bus.busy); end
        repeat (2) @(negedge clk);
        bus.req_valid = '0;
        #1;
        total++; if (bus.filt_in !== held) begin bad++; $display("FAIL drop_filt_in_busy got=%h want=%h", bus.filt_in, held); end
        c = 0;
        while (bus.rsp_valid == '0 && c < 30) begin @(negedge clk); #1; c++; end
        total++; if (bus.rsp_valid !== 4'b0001) begin bad++; $display("FAIL drop_rsp got=%b want=0001", bus.rsp_valid); end
        bus.rsp_ready = '1;
        m_ptr = 0;
        for (int i = 0; i < NR; i++) words[i] = $urandom;
        load_words();
        repeat (4) @(negedge clk);
        #1;
        total++; if (bus.busy !== 1'b0 || bus.grant_id !== '0) begin bad++; $display("FAIL drop_no_grant got=%b/%0d want=0/0", bus.busy, bus.grant_id); end
        total++; if (bus.filt_in !== held) begin bad++; $display("FAIL drop_filt_in_idle got=%h want=%h", bus.filt_in, held); end
        run_txn(4'b0100, g, ra, rn, fn, rv, s, m, lat, to);
        total++; if (g !== 2 || fn !== words[2]) begin bad++; $display("FAIL drop_next_accept got=%0d/%h want=2/%h", g, fn, words[2]); end
        m_ptr = 2;
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        int g, lat, eg; bit to;
        logic [NR-1:0] ra, rn, rv, vm; logic [BW-1:0] fn, s; logic [3:0] m;
        for (int t = 0; t < 24; t++) begin
            vm = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) words[i] = $urandom;
            load_words();
            eg = model_grant(vm, m_ptr);
            run_txn(vm, g, ra, rn, fn, rv, s, m, lat, to);
            total++; if (to) begin bad++; $display("FAIL rand_timeout txn=%0d got=timeout want=response", t); end
            total++; if (g !== eg) begin bad++; $display("FAIL rand_grant txn=%0d mask=%b got=%0d want=%0d", t, vm, g, eg); end
            total++; if (fn !== words[eg]) begin bad++; $display("FAIL rand_filt_in txn=%0d got=%h want=%h", t, fn, words[eg]); end
            total++; if (lat !== LAT + 2) begin bad++; $display("FAIL rand_latency txn=%0d got=%0d want=%0d", t, lat, LAT + 2); end
            total++; if (rv !== (NR'(1) << eg)) begin bad++; $display("FAIL rand_rsp_valid txn=%0d got=%b want=%b", t, rv, NR'(1) << eg); end
            total++; if (s !== ref_sort(words[eg]) || m !== ref_med(words[eg])) begin bad++; $display("FAIL rand_data txn=%0d got=%h/%h want=%h/%h", t, s, m, ref_sort(words[eg]), ref_med(words[eg])); end
            m_ptr = eg;
        end
        bus.req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=no_finish want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_data = '0;
        for (int i = 0; i < NR; i++) words[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_drop();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
